// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the RV32IM ID-stage control unit: opcodes, ALU operation
// codes, immediate-format selects, FSM states and the registered control bundle.
package rv32_ctrl_pkg;

  localparam int ALU_W    = 5;
  localparam int IMMSEL_W = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [ALU_W-1:0] ALU_ADD    = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_XOR    = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_AND    = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_OR     = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_MUL    = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_SLL    = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_SRL    = 5'b00110;
  localparam logic [ALU_W-1:0] ALU_SLT    = 5'b00111;
  localparam logic [ALU_W-1:0] ALU_DIV    = 5'b01000;
  localparam logic [ALU_W-1:0] ALU_DIVU   = 5'b01001;
  localparam logic [ALU_W-1:0] ALU_REM    = 5'b01010;
  localparam logic [ALU_W-1:0] ALU_REMU   = 5'b01011;
  localparam logic [ALU_W-1:0] ALU_MULH   = 5'b01100;
  localparam logic [ALU_W-1:0] ALU_MULHSU = 5'b01101;
  localparam logic [ALU_W-1:0] ALU_MULHU  = 5'b01110;
  localparam logic [ALU_W-1:0] ALU_SLTU   = 5'b01111;
  localparam logic [ALU_W-1:0] ALU_SUB    = 5'b10000;
  localparam logic [ALU_W-1:0] ALU_PASSB  = 5'b10001;
  localparam logic [ALU_W-1:0] ALU_SRA    = 5'b10110;

  localparam logic [IMMSEL_W-1:0] IMM_I = 3'b000;
  localparam logic [IMMSEL_W-1:0] IMM_S = 3'b001;
  localparam logic [IMMSEL_W-1:0] IMM_U = 3'b010;
  localparam logic [IMMSEL_W-1:0] IMM_B = 3'b011;
  localparam logic [IMMSEL_W-1:0] IMM_J = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_VALID = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  // All-zero value of this struct is the NOP bundle (ADD, I-format, no enables).
  typedef struct packed {
    logic [ALU_W-1:0]    alu_opcode;
    logic                pc_sel;
    logic                imm_sel;
    logic                wb_mem_sel;
    logic                regwrite_enable;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic                jal_select;
    logic [IMMSEL_W-1:0] imm_select;
  } ctrl_bundle_t;

  function automatic logic [ALU_W-1:0] alu_base(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_muldiv(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32IM instruction decode into the control bundle plus M-op class.
// With ILLEGAL_TRAP_EN defined, unknown encodings also raise illegal.
module control_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle,
  output logic         is_mul,
  output logic         is_div,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    bundle = '0;
    is_mul = 1'b0;
    is_div = 1'b0;
    bad    = 1'b0;
    case (opcode)
      OP_R: begin
        bundle.regwrite_enable = 1'b1;
        case (funct7)
          F7_BASE: bundle.alu_opcode = alu_base(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      bundle.alu_opcode = ALU_SUB;
            else if (funct3 == 3'b101) bundle.alu_opcode = ALU_SRA;
            else                       bad = 1'b1;
          end
          F7_MULDIV: begin
            bundle.alu_opcode = alu_muldiv(funct3);
            is_mul = !funct3[2];
            is_div = funct3[2];
          end
          default: bad = 1'b1;
        endcase
      end
      OP_OPIMM: begin
        bundle.imm_sel         = 1'b1;
        bundle.regwrite_enable = 1'b1;
        // Shift-immediates reuse funct7 as a qualifier; everything else ignores it.
        if (funct3 == 3'b001) begin
          if (funct7 == F7_BASE) bundle.alu_opcode = ALU_SLL;
          else                   bad = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE)     bundle.alu_opcode = ALU_SRL;
          else if (funct7 == F7_ALT) bundle.alu_opcode = ALU_SRA;
          else                       bad = 1'b1;
        end else begin
          bundle.alu_opcode = alu_base(funct3);
        end
      end
      OP_LOAD: begin
        bundle.imm_sel         = 1'b1;
        bundle.regwrite_enable = 1'b1;
        bundle.mem_read        = 1'b1;
        bundle.wb_mem_sel      = 1'b1;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        bundle.imm_sel    = 1'b1;
        bundle.mem_write  = 1'b1;
        bundle.imm_select = IMM_S;
        bad = funct3[2] || (funct3 == 3'b011);
      end
      OP_BRANCH: begin
        bundle.branch     = 1'b1;
        bundle.imm_select = IMM_B;
        if (!funct3[2])     bundle.alu_opcode = ALU_SUB;
        else if (!funct3[1]) bundle.alu_opcode = ALU_SLT;
        else                bundle.alu_opcode = ALU_SLTU;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        bundle.pc_sel          = 1'b1;
        bundle.imm_sel         = 1'b1;
        bundle.regwrite_enable = 1'b1;
        bundle.jump            = 1'b1;
        bundle.jal_select      = 1'b1;
        bundle.imm_select      = IMM_J;
      end
      OP_JALR: begin
        bundle.imm_sel         = 1'b1;
        bundle.regwrite_enable = 1'b1;
        bundle.jump            = 1'b1;
        bundle.jal_select      = 1'b1;
        bad = (funct3 != 3'b000);
      end
      OP_AUIPC: begin
        bundle.pc_sel          = 1'b1;
        bundle.imm_sel         = 1'b1;
        bundle.regwrite_enable = 1'b1;
        bundle.imm_select      = IMM_U;
      end
      OP_LUI: begin
        bundle.imm_sel         = 1'b1;
        bundle.regwrite_enable = 1'b1;
        bundle.alu_opcode      = ALU_PASSB;
        bundle.imm_select      = IMM_U;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      bundle = '0;
      is_mul = 1'b0;
      is_div = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = bad;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control unit: decodes IF/ID, registers the bundle into ID/EX with valid/ready,
// flush, and a hold for multi-cycle M ops. ILLEGAL_TRAP_EN enables illegal_instr reporting.
module pipelined_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 32
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [31:0]        instruction,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [ALUOP_W-1:0] alu_opcode,
  output logic               pc_sel,
  output logic               imm_sel,
  output logic               wb_mem_sel,
  output logic               regwrite_enable,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               jump,
  output logic               jal_select,
  output logic [2:0]         imm_select,
  output logic               md_busy,
  output logic               illegal_instr
);

  // Counter is sized for the longer of the two latencies so either op fits.
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // Valid/ready: an instruction is accepted on in_valid & in_ready (and no flush);
  // the bundle leaves on out_valid & out_ready; both sides may transfer in one cycle.
  state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  ctrl_bundle_t bundle_q, bundle_d;
  logic         illegal_q, illegal_d;
  logic         out_valid_q, out_valid_d;
  logic         md_busy_q, md_busy_d;

  ctrl_bundle_t     dec_bundle;
  logic             dec_is_mul;
  logic             dec_is_div;
  logic             dec_illegal;
  logic [CNT_W-1:0] dec_lat;
  logic             accept;

  control_decoder u_decoder (
    .instr   (instruction),
    .bundle  (dec_bundle),
    .is_mul  (dec_is_mul),
    .is_div  (dec_is_div),
    .illegal (dec_illegal)
  );

  assign dec_lat = dec_is_div ? CNT_W'(DIV_LAT - 1) :
                   dec_is_mul ? CNT_W'(MUL_LAT - 1) : '0;

  // A held bundle that will enter HOLD on departure cannot be replaced in the same cycle.
  assign in_ready = !md_busy_q && (!out_valid_q || (out_ready && (lat_q == '0)));
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    bundle_d  = bundle_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      lat_d     = '0;
      bundle_d  = '0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d   = ST_VALID;
            bundle_d  = dec_bundle;
            illegal_d = dec_illegal;
            lat_d     = dec_lat;
          end
        end
        ST_VALID: begin
          if (accept) begin
            bundle_d  = dec_bundle;
            illegal_d = dec_illegal;
            lat_d     = dec_lat;
          end else if (out_ready) begin
            bundle_d  = '0;
            illegal_d = 1'b0;
            lat_d     = '0;
            if (lat_q != '0) begin
              state_d = ST_HOLD;
              cnt_d   = lat_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          lat_d     = '0;
          bundle_d  = '0;
          illegal_d = 1'b0;
        end
      endcase
    end
    out_valid_d = (state_d == ST_VALID);
    md_busy_d   = (state_d == ST_HOLD);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      bundle_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      md_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      bundle_q    <= bundle_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      md_busy_q   <= md_busy_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign md_busy         = md_busy_q;
  assign illegal_instr   = illegal_q;
  assign alu_opcode      = ALUOP_W'(bundle_q.alu_opcode);
  assign pc_sel          = bundle_q.pc_sel;
  assign imm_sel         = bundle_q.imm_sel;
  assign wb_mem_sel      = bundle_q.wb_mem_sel;
  assign regwrite_enable = bundle_q.regwrite_enable;
  assign mem_read        = bundle_q.mem_read;
  assign mem_write       = bundle_q.mem_write;
  assign branch          = bundle_q.branch;
  assign jump            = bundle_q.jump;
  assign jal_select      = bundle_q.jal_select;
  assign imm_select      = bundle_q.imm_select;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed steps then random traffic against a
// transaction-level model (expected-bundle queue plus hold countdown).
module tb_pipelined_control_unit;

  localparam int MUL_LAT = 1;
  localparam int DIV_LAT = 4;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] instruction = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, pc_sel, imm_sel, wb_mem_sel, regwrite_enable;
  logic        mem_read, mem_write, branch, jump, jal_select, md_busy, illegal_instr;
  logic [4:0]  alu_opcode;
  logic [2:0]  imm_select;

  pipelined_control_unit #(.ALUOP_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .instruction(instruction), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .alu_opcode(alu_opcode), .pc_sel(pc_sel), .imm_sel(imm_sel), .wb_mem_sel(wb_mem_sel),
    .regwrite_enable(regwrite_enable), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .jal_select(jal_select), .imm_select(imm_select),
    .md_busy(md_busy), .illegal_instr(illegal_instr)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [17:0] exp_q[$];
  bit          m_valid = 0;
  int          m_hold = 0;
  int          m_lat = 0;

  wire [17:0] obs_bundle = {alu_opcode, pc_sel, imm_sel, wb_mem_sel, regwrite_enable, mem_read,
                            mem_write, branch, jump, jal_select, imm_select, illegal_instr};

  // Expected bundle {alu, pc_sel, imm_sel, wb_mem, rw, mrd, mwr, br, jmp, jal, imm_select, illegal}.
  function automatic logic [17:0] ref_decode(input logic [31:0] ins);
    logic [6:0] op, f7;
    logic [2:0] f3, isel;
    logic [4:0] alu;
    bit a_pc, b_imm, wb, rw, mr, mw, br, jp, jl, bad, ill;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    alu = 5'd0; isel = 3'd0;
    {a_pc, b_imm, wb, rw, mr, mw, br, jp, jl, bad} = '0;
    case (op)
      7'h33: begin
        rw = 1;
        if (f7 == 7'h00) alu = base_op(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 5'b10000;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 5'b10110;
        else if (f7 == 7'h01) alu = md_op(f3);
        else bad = 1;
      end
      7'h13: begin
        rw = 1; b_imm = 1;
        if (f3 == 3'd1) begin alu = 5'b00101; bad = (f7 != 7'h00); end
        else if (f3 == 3'd5 && f7 == 7'h00) alu = 5'b00110;
        else if (f3 == 3'd5 && f7 == 7'h20) alu = 5'b10110;
        else if (f3 == 3'd5) bad = 1;
        else alu = base_op(f3);
      end
      7'h03: begin rw = 1; b_imm = 1; mr = 1; wb = 1; bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin b_imm = 1; mw = 1; isel = 3'd1; bad = (f3 > 3'd2); end
      7'h63: begin
        br = 1; isel = 3'd3;
        alu = (f3 < 3'd2) ? 5'b10000 : (f3 < 3'd6) ? 5'b00111 : 5'b01111;
        bad = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h6F: begin a_pc = 1; b_imm = 1; rw = 1; jp = 1; jl = 1; isel = 3'd4; end
      7'h67: begin b_imm = 1; rw = 1; jp = 1; jl = 1; bad = (f3 != 3'd0); end
      7'h17: begin a_pc = 1; b_imm = 1; rw = 1; isel = 3'd2; end
      7'h37: begin b_imm = 1; rw = 1; alu = 5'b10001; isel = 3'd2; end
      default: bad = 1;
    endcase
`ifdef ILLEGAL_TRAP_EN
    ill = bad;
`else
    ill = 0;
`endif
    if (bad) return {17'd0, ill};
    return {alu, a_pc, b_imm, wb, rw, mr, mw, br, jp, jl, isel, ill};
  endfunction

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 5'b00000; 3'd1: return 5'b00101; 3'd2: return 5'b00111; 3'd3: return 5'b01111;
      3'd4: return 5'b00001; 3'd5: return 5'b00110; 3'd6: return 5'b00011; default: return 5'b00010;
    endcase
  endfunction

  function automatic logic [4:0] md_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 5'b00100; 3'd1: return 5'b01100; 3'd2: return 5'b01101; 3'd3: return 5'b01110;
      3'd4: return 5'b01000; 3'd5: return 5'b01001; 3'd6: return 5'b01010; default: return 5'b01011;
    endcase
  endfunction

  // Extra EX cycles after the bundle leaves during which decode must stall.
  function automatic int ref_hold(input logic [31:0] ins);
    if (ins[6:0] != 7'h33 || ins[31:25] != 7'h01) return 0;
    return ins[14] ? DIV_LAT - 1 : MUL_LAT - 1;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [6:0] op, f7;
    ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h17, 7'h37};
    if ($urandom_range(0, 7) == 0) return $urandom();
    op = ops[$urandom_range(0, 8)];
    case ($urandom_range(0, 4))
      0, 1: f7 = 7'h00;
      2: f7 = 7'h20;
      3: f7 = 7'h01;
      default: f7 = 7'($urandom());
    endcase
    return {f7, 5'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()), op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid = v; instruction = ins; out_ready = ordy; flush = fl;
  endtask

  task automatic model_reset();
    exp_q.delete(); m_valid = 0; m_hold = 0; m_lat = 0;
  endtask

  // One clock: check in_ready, advance the model, check registered outputs.
  task automatic tick(input string tag);
    bit rdy, acc, leave;
    #1;
    rdy = (m_hold == 0) && (!m_valid || (out_ready && m_lat == 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    acc = in_valid && rdy && !flush;
    leave = m_valid && out_ready;
    if (flush) model_reset();
    else if (m_hold > 0) m_hold--;
    else begin
      if (leave) begin
        void'(exp_q.pop_front());
        m_valid = 0;
        if (!acc) m_hold = m_lat;
        m_lat = 0;
      end
      if (acc) begin
        exp_q.push_back(ref_decode(instruction));
        m_valid = 1;
        m_lat = ref_hold(instruction);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".md_busy"}, 32'(md_busy), 32'(m_hold > 0));
    chk({tag, ".bundle"}, 32'(obs_bundle), m_valid ? 32'(exp_q[0]) : 32'd0);
  endtask

  initial begin
    int busy_cycles;
    int guard;
    bit exp_ill;

    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.md_busy", 32'(md_busy), 32'd0);
    chk("rst.bundle", 32'(obs_bundle), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;

    drive(1, I_ADD, 1, 0); tick("add");
    chk("add.alu", 32'(alu_opcode), 32'b00000);
    chk("add.regwrite", 32'(regwrite_enable), 32'd1);
    chk("add.imm_sel", 32'(imm_sel), 32'd0);
    drive(0, 0, 1, 0); tick("add_drain");

    drive(1, I_LW, 0, 0); tick("lw_acc");
    drive(1, I_ADD, 0, 0);
    repeat (3) tick("lw_stall");
    chk("lw.mem_read", 32'(mem_read), 32'd1);
    chk("lw.wb_mem_sel", 32'(wb_mem_sel), 32'd1);
    drive(1, I_ADD, 1, 0); tick("lw_release");
    chk("lw_release.alu", 32'(alu_opcode), 32'b00000);
    drive(0, 0, 1, 0); tick("lw_drain");

    drive(1, I_DIV, 1, 0); tick("div_acc");
    chk("div.alu", 32'(alu_opcode), 32'b01000);
    drive(1, I_ADD, 1, 0); tick("div_leave");
    busy_cycles = 0; guard = 0;
    while (in_ready !== 1'b1 && guard < 10) begin
      busy_cycles += (md_busy === 1'b1) ? 1 : 0;
      guard++;
      tick("div_hold");
    end
    chk("div.busy_cycles", 32'(busy_cycles), 32'd3);
    tick("add_after_div");
    chk("add_after_div.valid", 32'(out_valid), 32'd1);
    drive(0, 0, 1, 0); tick("div_drain");

    drive(1, I_ADD, 0, 0); tick("fl_load");
    drive(1, I_LW, 0, 1); tick("flush");
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    drive(0, 0, 1, 0); tick("flush_after");
    chk("flush.dropped", 32'(out_valid), 32'd0);

`ifdef ILLEGAL_TRAP_EN
    exp_ill = 1;
`else
    exp_ill = 0;
`endif
    drive(1, I_BAD, 1, 0); tick("bad");
    chk("bad.illegal", 32'(illegal_instr), 32'(exp_ill));
    chk("bad.regwrite", 32'(regwrite_enable), 32'd0);
    drive(0, 0, 1, 0); tick("bad_drain");

    drive(1, I_DIV, 1, 0); tick("rdiv_acc");
    drive(0, 0, 1, 0); tick("rdiv_leave");
    tick("rdiv_hold");
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.md_busy", 32'(md_busy), 32'd0);
    chk("midrst.bundle", 32'(obs_bundle), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick("post_rst");

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
